// File: rtl/toeplitz_hash.sv
// toeplitz_hash: Toeplitz privacy-amplification hasher, 2048 raw bits -> 1024-bit hash.
// Captures a seed window on shift_en, then consumes one raw bit per cycle, MSB first.
// Ports:
//   clk_in, rst_n            clock, synchronous active-low reset
//   seed, shift_en           seed from the seed reader and its level-valid
//   shift_ack                one-cycle pulse after the seed is captured
//   raw_data/valid/ready     32-bit raw word handshake (ready only while fetching)
//   hash/hash_valid/ready    held result handshake
//   blk_cnt                  completed-block counter, present only with TOEP_HASH_COUNT_EN
module toeplitz_hash #(
   parameter int SEED_W = 3072,
   parameter int IN_W   = 2048,
   parameter int OUT_W  = 1024
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [SEED_W-1:0] seed,
   input  logic              shift_en,
   output logic              shift_ack,
   input  logic [31:0]       raw_data,
   input  logic              raw_valid,
   output logic              raw_ready,
   output logic [OUT_W-1:0]  hash,
   output logic              hash_valid,
`ifdef TOEP_HASH_COUNT_EN
   output logic [15:0]       blk_cnt,
`endif
   input  logic              hash_ready
);

   localparam logic [5:0] LAST_WORD = 6'(IN_W / 32 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FETCH,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state;
   logic [SEED_W-1:0] win;
   logic [31:0]       sreg;
   logic [5:0]        wcnt;
   logic [4:0]        bcnt;

   // win slides right one bit per consumed raw bit, so its low OUT_W
   // bits are always seed[i +: OUT_W] for the current raw bit index i.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         shift_ack  <= 1'b0;
         raw_ready  <= 1'b0;
         hash_valid <= 1'b0;
         hash       <= '0;
         win        <= '0;
         sreg       <= '0;
         wcnt       <= '0;
         bcnt       <= '0;
`ifdef TOEP_HASH_COUNT_EN
         blk_cnt    <= '0;
`endif
      end else begin
         shift_ack <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (shift_en) begin
                  win       <= seed;
                  hash      <= '0;
                  shift_ack <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               raw_ready <= 1'b1;
               state     <= S_FETCH;
            end
            S_FETCH: begin
               if (raw_valid) begin
                  sreg      <= raw_data;
                  bcnt      <= '0;
                  raw_ready <= 1'b0;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (sreg[31]) begin
                  hash <= hash ^ win[OUT_W-1:0];
               end
               win  <= {1'b0, win[SEED_W-1:1]};
               sreg <= {sreg[30:0], 1'b0};
               bcnt <= bcnt + 5'd1;
               if (bcnt == 5'd31) begin
                  // 6-bit counter wraps back to 0 after the last word
                  wcnt <= wcnt + 6'd1;
                  if (wcnt == LAST_WORD) begin
                     hash_valid <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     raw_ready <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               if (hash_ready) begin
                  hash_valid <= 1'b0;
                  state      <= S_IDLE;
`ifdef TOEP_HASH_COUNT_EN
                  blk_cnt    <= blk_cnt + 16'd1;
`endif
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toeplitz_hash.sv
// tb_toeplitz_hash: scoreboard bench for toeplitz_hash.
// Driver queues expected hashes; a negedge monitor pops and compares on hash_valid.
module tb_toeplitz_hash;

   localparam int SEED_W = 3072;
   localparam int IN_W   = 2048;
   localparam int OUT_W  = 1024;
   localparam int NW     = IN_W / 32;
   localparam int LAT    = 2113;

   logic              clk_in = 1'b0;
   logic              rst_n;
   logic [SEED_W-1:0] seed;
   logic              shift_en;
   logic              shift_ack;
   logic [31:0]       raw_data;
   logic              raw_valid;
   logic              raw_ready;
   logic [OUT_W-1:0]  hash;
   logic              hash_valid;
   logic              hash_ready;
`ifdef TOEP_HASH_COUNT_EN
   logic [15:0]       blk_cnt;
`endif

   toeplitz_hash dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .seed       (seed),
      .shift_en   (shift_en),
      .shift_ack  (shift_ack),
      .raw_data   (raw_data),
      .raw_valid  (raw_valid),
      .raw_ready  (raw_ready),
      .hash       (hash),
      .hash_valid (hash_valid),
`ifdef TOEP_HASH_COUNT_EN
      .blk_cnt    (blk_cnt),
`endif
      .hash_ready (hash_ready)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [OUT_W-1:0] h;
      int               lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          fails  = 0;
   logic [31:0] words [NW];

   task automatic chk(input string name, input logic [OUT_W-1:0] act,
                      input logic [OUT_W-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [OUT_W-1:0] model(input logic [SEED_W-1:0] s);
      logic [OUT_W-1:0] h;
      logic             x;
      h = '0;
      for (int i = 0; i < IN_W; i++) begin
         x = words[i / 32][31 - (i % 32)];
         if (x) begin
            for (int j = 0; j < OUT_W; j++) h[j] = h[j] ^ s[i + j];
         end
      end
      return h;
   endfunction

   function automatic logic [SEED_W-1:0] rand_seed();
      logic [SEED_W-1:0] s;
      for (int k = 0; k < SEED_W / 32; k++) s[k*32 +: 32] = $urandom;
      return s;
   endfunction

   task automatic rand_words();
      for (int k = 0; k < NW; k++) words[k] = $urandom;
   endtask

   task automatic zero_words();
      for (int k = 0; k < NW; k++) words[k] = '0;
   endtask

   // monitor: scoreboard pop, latency since shift_ack, ack count, stability
   initial begin : mon
      logic             prev_v;
      logic [OUT_W-1:0] held;
      int               since;
      int               acks;
      exp_t             e;
      prev_v = 1'b0;
      held   = '0;
      since  = 0;
      acks   = 0;
      forever begin
         @(negedge clk_in);
         if (!rst_n) begin
            prev_v = 1'b0;
            since  = 0;
            acks   = 0;
         end else begin
            if (shift_ack) begin
               acks++;
               since = 0;
            end else begin
               since++;
            end
            chk("ready_outside_fetch",
                OUT_W'(raw_ready & (hash_valid | shift_ack)), '0);
            if (hash_valid && !prev_v) begin
               if (sb.size() == 0) begin
                  chk("unexpected_valid", OUT_W'(1), '0);
               end else begin
                  e = sb.pop_front();
                  chk("hash", hash, e.h);
                  if (e.lat >= 0) chk("latency", OUT_W'(since), OUT_W'(e.lat));
                  chk("acks_per_block", OUT_W'(acks), OUT_W'(1));
                  acks = 0;
                  held = hash;
               end
            end else if (hash_valid) begin
               chk("hash_stable", hash, held);
            end
            prev_v = hash_valid;
         end
      end
   end

   task automatic start_seed(input logic [SEED_W-1:0] s, input bit hold);
      int n;
      n        = 0;
      seed     = s;
      shift_en = 1'b1;
      do begin
         @(negedge clk_in);
         n++;
      end while (!shift_ack && n < 5000);
      chk("ack_seen", OUT_W'(shift_ack), OUT_W'(1));
      chk("hash_clear", hash, '0);
      @(posedge clk_in);
      #1;
      if (!hold) shift_en = 1'b0;
      chk("ack_pulse", OUT_W'(shift_ack), '0);
   endtask

   task automatic feed(input int nwords, input bit stall);
      bit acc;
      int n;
      for (int k = 0; k < nwords; k++) begin
         if (stall) begin
            raw_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk_in);
               #1;
            end
         end
         raw_data  = words[k];
         raw_valid = 1'b1;
         acc       = 1'b0;
         n         = 0;
         while (!acc && n < 200) begin
            @(negedge clk_in);
            acc = raw_ready;
            @(posedge clk_in);
            #1;
            n++;
         end
         if (!acc) chk("word_accept_timeout", OUT_W'(k), '1);
         raw_valid = 1'b0;
      end
   endtask

   task automatic finish_blk(input int delay, input logic [OUT_W-1:0] req);
      int n;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!hash_valid && n < 3000);
      chk("valid_seen", OUT_W'(hash_valid), OUT_W'(1));
      if (delay < 0) begin
         @(posedge clk_in);
         #1;
      end else begin
         repeat (delay) @(posedge clk_in);
         #1;
         hash_ready = 1'b1;
         @(posedge clk_in);
         #1;
         hash_ready = 1'b0;
      end
      chk("valid_fall", OUT_W'(hash_valid), '0);
      chk("hash_hold", hash, req);
   endtask

   task automatic run_block(input logic [SEED_W-1:0] s, input logic [OUT_W-1:0] req,
                            input int lat, input bit stall, input int delay,
                            input bit hold);
      exp_t e;
      e.h   = req;
      e.lat = lat;
      sb.push_back(e);
      if (delay < 0) hash_ready = 1'b1;
      start_seed(s, hold);
      feed(NW, stall);
      finish_blk(delay, req);
      hash_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk_in);
      #1;
      rst_n = 1'b0;
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"}, OUT_W'(shift_ack), '0);
      chk({tag, "_ready"}, OUT_W'(raw_ready), '0);
      chk({tag, "_valid"}, OUT_W'(hash_valid), '0);
      chk({tag, "_hash"}, hash, '0);
`ifdef TOEP_HASH_COUNT_EN
      chk({tag, "_blk_cnt"}, OUT_W'(blk_cnt), '0);
`endif
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin : drv
      logic [SEED_W-1:0] s;
      logic [OUT_W-1:0]  h;
      seed       = '0;
      shift_en   = 1'b0;
      raw_data   = '0;
      raw_valid  = 1'b0;
      hash_ready = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      chk_idle_outputs("reset");

      // reset in the middle of SHIFT discards the block
      s = rand_seed();
      rand_words();
      start_seed(s, 1'b0);
      feed(3, 1'b0);
      repeat (5) @(posedge clk_in);
      #1;
      do_reset();
      chk_idle_outputs("mid_reset");
      repeat (3) @(posedge clk_in);
      #1;
      chk("mid_reset_idle_ready", OUT_W'(raw_ready), '0);

      // fresh block after reset, checked against the formula model
      run_block(s, model(s), LAT, 1'b0, 2, 1'b0);

      // seed bit 0, raw bit 0 -> hash = 1, hash_ready held high
      zero_words();
      words[0] = 32'h8000_0000;
      s        = '0;
      s[0]     = 1'b1;
      run_block(s, OUT_W'(1), LAT, 1'b0, -1, 1'b0);
      repeat (5) @(posedge clk_in);
      #1;
      chk("hash_idle_hold", hash, OUT_W'(1));

      // seed bit 100, raw bit 40 -> hash bit 60
      zero_words();
      words[1] = 32'h0080_0000;
      s        = '0;
      s[100]   = 1'b1;
      h        = '0;
      h[60]    = 1'b1;
      run_block(s, h, LAT, 1'b0, 0, 1'b0);

      // all-zero raw block
      zero_words();
      run_block(rand_seed(), '0, LAT, 1'b0, 0, 1'b0);

      // random block with raw_valid gaps
      s = rand_seed();
      rand_words();
      run_block(s, model(s), -1, 1'b1, 3, 1'b0);

      // shift_en held across three blocks, hash_ready delayed 10 cycles
      do_reset();
      chk_idle_outputs("pre_multi");
      s = rand_seed();
      for (int b = 0; b < 3; b++) begin
         rand_words();
         run_block(s, model(s), LAT, 1'b0, 10, b < 2);
      end
`ifdef TOEP_HASH_COUNT_EN
      chk("blk_cnt_3", OUT_W'(blk_cnt), OUT_W'(3));
      do_reset();
      chk("blk_cnt_reset", OUT_W'(blk_cnt), '0);
`endif

      repeat (4) @(posedge clk_in);
      #1;
      chk("scoreboard_empty", OUT_W'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
